colour_rom_arbiter: RTL
=======================

// Module: colour_rom_arbiter
// PURPOSE
//  Shares one single-port 8x24 colour ROM (clka/ena/addra/douta, READ_LATENCY-cycle read) between NUM_REQ requesters.
//  Per cycle: picks one valid request, issues its colour code as a ROM read, tracks the requester ID through the ROM
//  latency, returns the 24-bit RGB word tagged to that requester. ROM instance sits outside; this block drives its ports.
// PARAMETERS
//  NUM_REQ       2  number of requesters, legal 2..8
//  READ_LATENCY  1  ROM read latency in cycles (addr/en at T -> douta valid at T+READ_LATENCY), legal 1..2
//  ID_W          $clog2(NUM_REQ)  derived; width of requester index
// PORTS
//  clk        in   1             single clock, all logic rising-edge
//  rst_n      in   1             asynchronous active-low reset
//  req_valid  in   NUM_REQ       requester i has a lookup pending
//  req_colour in   3*NUM_REQ     colour code of requester i at [3*i+:3]
//  req_ready  out  NUM_REQ       one-hot (or zero): request i accepted this cycle
//  mem_en     out  1             ROM enable
//  mem_addr   out  3             ROM address (colour code)
//  mem_rdata  in   24            ROM read data
//  rsp_valid  out  NUM_REQ       one-hot (or zero): response for requester i valid this cycle
//  rsp_rgb    out  24            RGB word, valid only with rsp_valid
//  rsp_id     out  ID_W          index of responding requester
// BEHAVIOUR
//  - Reset (async assert, sync deassert by clock): rsp_valid=0, rsp_rgb=24'h0, rsp_id=0, pipeline valid bits=0,
//    RR pointer=NUM_REQ-1 (so requester 0 wins first). req_ready/mem_en are combinational: 0 while rst_n=0.
//  - Arbitration (combinational, cycle T): grant g = selected index among req_valid bits; req_ready[g]=1;
//    mem_en=1; mem_addr=req_colour[3*g+:3]. No valid request: req_ready=0, mem_en=0, mem_addr=0.
//  - Handshake: transfer when req_valid[i] & req_ready[i]. Requester holds valid/colour until ready; may drop valid
//    at any time without penalty. At most one acceptance per cycle; one read issued per accepted request.
//  - Tracking: shift register of depth READ_LATENCY holding {valid, id}; entry written at T with {1,g}.
//  - Response: at T+READ_LATENCY, rsp_rgb<=mem_rdata, rsp_id<=id, rsp_valid<=onehot(id) (registered), so
//    rsp outputs valid in cycle T+READ_LATENCY+1 (=T+2 default). No response backpressure; requester must sink it.
//  - Pipelined: back-to-back acceptances give back-to-back responses, full throughput 1/cycle, order preserved.
//  - rsp_rgb holds last value when rsp_valid=0; rsp_valid is a single-cycle pulse per response.
//  - Reset mid-operation: all in-flight reads dropped, no response generated for them; RR pointer restarts.
//  - Colour codes 0..7 all legal; no wrap/overflow arithmetic. req_colour of non-granted requesters ignored.
// CONFIGURATION
//  COLOUR_ARB_RR_EN defined: round-robin; search starts at (ptr+1) mod NUM_REQ, wraps past NUM_REQ-1 to 0;
//    ptr<=g on each acceptance only; ptr unchanged on idle cycles. No requester starved: wait <= NUM_REQ-1 grants.
//  COLOUR_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register; starvation permitted.
// TESTING (bench ROM model: READ_LATENCY=1, douta = 24'h111111*addr; NUM_REQ=2 unless noted)
//  1 Reset: rst_n=0 mid-stream with 2 reads in flight -> rsp_valid stays 0 through release, no stale responses.
//  2 Single: req_valid=2'b01, colour0=5 at T -> req_ready=01,mem_addr=5 at T; rsp_valid=01,rsp_rgb=24'h555555 at T+2.
//  3 Stream: requester1 holds valid, colours 1,2,3 over 3 cycles -> responses 24'h111111,222222,333333 on 3
//    consecutive cycles starting T+2, rsp_id=1 each.
//  4 Contention RR (macro on): both valid continuously, colour0=7, colour1=4 -> grants 0,1,0,1...;
//    responses alternate 24'h777777 (id0), 24'h444444 (id1).
//  5 Contention fixed (macro off): both valid 4 cycles -> req_ready=01 all 4 cycles, requester1 granted only after
//    req_valid[0] drops; NUM_REQ=4 all valid -> only index 0 granted.
//  6 RR wrap, NUM_REQ=4 (macro on): all valid, ptr=3 after grant to 3 -> next grant 0; idle cycle between keeps ptr.

Source files
------------

// File: rtl/colour_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : colour_rom_arbiter
// Brief    : Shares one single-port 8x24 colour ROM between NUM_REQ requesters
//            and returns each RGB word tagged with the requester that asked.
//            Define COLOUR_ARB_RR_EN for round-robin arbitration, otherwise
//            fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module colour_rom_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int READ_LATENCY = 1,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [3*NUM_REQ-1:0]   req_colour,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   mem_en,
    output logic [2:0]             mem_addr,
    input  logic [23:0]            mem_rdata,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [23:0]            rsp_rgb,
    output logic [ID_W-1:0]        rsp_id
);

    localparam int c_last_stage = READ_LATENCY - 1;

    logic                               w_grant_vld;
    logic [ID_W-1:0]                    w_grant_id;
    int                                 w_idx;
    logic [READ_LATENCY-1:0]            r_pipe_vld;
    logic [READ_LATENCY-1:0][ID_W-1:0]  r_pipe_id;

`ifdef COLOUR_ARB_RR_EN
    logic [ID_W-1:0]                    r_ptr;
`endif

    // Search order starts just after the last winner (round-robin) or at 0.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef COLOUR_ARB_RR_EN
            w_idx = int'(r_ptr) + 1 + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
`else
            w_idx = k;
`endif
            if (rst_n && !w_grant_vld && req_valid[w_idx[ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_grant_vld && (w_grant_id == ID_W'(i));
        end
    end

    assign mem_en   = w_grant_vld;
    assign mem_addr = w_grant_vld ? req_colour[3*w_grant_id +: 3] : 3'd0;

    // The tag pipeline mirrors the ROM latency so the last stage lines up
    // with the cycle in which mem_rdata belongs to that requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
            rsp_valid  <= '0;
            rsp_rgb    <= 24'h0;
            rsp_id     <= '0;
        end else begin
            r_pipe_vld[0] <= w_grant_vld;
            r_pipe_id[0]  <= w_grant_id;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_id[s]  <= r_pipe_id[s-1];
            end
            if (r_pipe_vld[c_last_stage]) begin
                rsp_rgb <= mem_rdata;
                rsp_id  <= r_pipe_id[c_last_stage];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid[i] <= r_pipe_vld[c_last_stage] &&
                                (r_pipe_id[c_last_stage] == ID_W'(i));
            end
        end
    end

`ifdef COLOUR_ARB_RR_EN
    // Pointer only moves on an acceptance; idle cycles keep the rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= ID_W'(NUM_REQ - 1);
        end else if (w_grant_vld) begin
            r_ptr <= w_grant_id;
        end
    end
`endif

endmodule
`default_nettype wire
